// File: rtl/top_speed.sv
// Speed trap: times a vehicle between entry and exit sensors 10 m apart,
// divides to get speed in 0.1 km/h units and reports it over a 2-byte UART frame.
module top_speed #(
  parameter int SYS_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int WIDTH_TIK   = 16,
  parameter int WIDTH_MS    = 12,
  parameter int WIDTH_SPEED = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor1,
  input  logic sensor2,
  input  logic sensor3,
  input  logic valid_Epass,
  input  logic enable,
  output logic serial_data_out
);

  localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DIV_W        = 19;

  localparam logic [WIDTH_TIK-1:0] TIK_MAX   = WIDTH_TIK'(SYS_FREQ / 32'd1000 - 32'd1);
  localparam logic [BAUD_W-1:0]    BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [WIDTH_MS-1:0]  MS_MAX    = {WIDTH_MS{1'b1}};
  localparam logic [DIV_W-1:0]     DIVIDEND  = 19'd360000;
  localparam logic [DIV_W-1:0]     SPEED_MAX = DIV_W'((32'd1 << WIDTH_SPEED) - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } state_t;

  // bit order: 0 sensor1, 1 sensor2, 2 sensor3, 3 valid_Epass, 4 enable
  logic [4:0] async_s;
  logic [4:0] meta_r;
  logic [4:0] sync_r;
  logic [2:0] prev_r;
  logic       s1_rise_s;
  logic       s2_rise_s;
  logic       s3_rise_s;
  logic       s3_fall_s;

  state_t                 state_r;
  logic [WIDTH_TIK-1:0]   tik_r;
  logic [WIDTH_MS-1:0]    ms_r;
  logic [WIDTH_MS-1:0]    elapsed_r;
  logic                   epass_ok_r;
  logic                   barrier_r;
  logic [WIDTH_MS-1:0]    rem_r;
  logic [DIV_W-1:0]       quo_r;
  logic [4:0]             div_cnt_r;
  logic [19:0]            frame_r;
  logic [4:0]             bit_cnt_r;
  logic [BAUD_W-1:0]      baud_cnt_r;

  logic [WIDTH_MS:0]      trial_s;
  logic [WIDTH_MS:0]      diff_s;
  logic                   ge_s;
  logic                   sat_s;
  logic [WIDTH_SPEED-1:0] speed_s;
  logic [15:0]            speed16_s;
  logic [7:0]             byte0_s;
  logic [7:0]             byte1_s;

  assign async_s   = {enable, valid_Epass, sensor3, sensor2, sensor1};
  assign s1_rise_s = sync_r[0] & ~prev_r[0];
  assign s2_rise_s = sync_r[1] & ~prev_r[1];
  assign s3_rise_s = sync_r[2] & ~prev_r[2];
  assign s3_fall_s = ~sync_r[2] & prev_r[2];

  // Two-flop synchronizers plus a history stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      meta_r <= 5'd0;
      sync_r <= 5'd0;
      prev_r <= 3'd0;
    end else begin
      meta_r <= async_s;
      sync_r <= meta_r;
      prev_r <= sync_r[2:0];
    end
  end

  // Restoring-divider step and frame byte assembly.
  always_comb begin
    trial_s   = {rem_r, quo_r[DIV_W-1]};
    diff_s    = trial_s - {1'b0, elapsed_r};
    ge_s      = (trial_s >= {1'b0, elapsed_r});
    sat_s     = (elapsed_r == {WIDTH_MS{1'b0}}) || (quo_r > SPEED_MAX);
    speed_s   = sat_s ? SPEED_MAX[WIDTH_SPEED-1:0] : quo_r[WIDTH_SPEED-1:0];
    speed16_s = 16'(speed_s);
    byte0_s   = {epass_ok_r, barrier_r | sync_r[4], speed16_s[13:8]};
    byte1_s   = speed16_s[7:0];
  end

  // Main sequencer: timing, division, UART transmit.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r         <= IDLE;
      tik_r           <= {WIDTH_TIK{1'b0}};
      ms_r            <= {WIDTH_MS{1'b0}};
      elapsed_r       <= {WIDTH_MS{1'b0}};
      epass_ok_r      <= 1'b0;
      barrier_r       <= 1'b0;
      rem_r           <= {WIDTH_MS{1'b0}};
      quo_r           <= {DIV_W{1'b0}};
      div_cnt_r       <= 5'd0;
      frame_r         <= {20{1'b1}};
      bit_cnt_r       <= 5'd0;
      baud_cnt_r      <= {BAUD_W{1'b0}};
      serial_data_out <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          serial_data_out <= 1'b1;
          if (s1_rise_s) begin
            tik_r   <= {WIDTH_TIK{1'b0}};
            ms_r    <= {WIDTH_MS{1'b0}};
            state_r <= TIMING;
          end
        end
        TIMING: begin
          serial_data_out <= 1'b1;
          if (tik_r == TIK_MAX) begin
            tik_r <= {WIDTH_TIK{1'b0}};
            ms_r  <= ms_r + WIDTH_MS'(1'b1);
          end else begin
            tik_r <= tik_r + WIDTH_TIK'(1'b1);
          end
          if (s2_rise_s) begin
            epass_ok_r <= sync_r[3];
            if (sync_r[3]) begin
              barrier_r <= 1'b1;
            end
          end
          if (s3_rise_s) begin
            elapsed_r <= ms_r;
            rem_r     <= {WIDTH_MS{1'b0}};
            quo_r     <= DIVIDEND;
            div_cnt_r <= 5'd0;
            state_r   <= CALC;
          end else if (ms_r == MS_MAX) begin
            epass_ok_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        CALC: begin
          serial_data_out <= 1'b1;
          if (div_cnt_r == 5'd19) begin
            // The frame is frozen here so later input activity cannot alter it.
            frame_r    <= {1'b1, byte1_s, 1'b0, 1'b1, byte0_s, 1'b0};
            bit_cnt_r  <= 5'd0;
            baud_cnt_r <= {BAUD_W{1'b0}};
            state_r    <= SEND;
          end else begin
            rem_r     <= ge_s ? diff_s[WIDTH_MS-1:0] : trial_s[WIDTH_MS-1:0];
            quo_r     <= {quo_r[DIV_W-2:0], ge_s};
            div_cnt_r <= div_cnt_r + 5'd1;
          end
        end
        SEND: begin
          serial_data_out <= frame_r[0];
          if (baud_cnt_r == BAUD_MAX) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            frame_r    <= {1'b1, frame_r[19:1]};
            if (bit_cnt_r == 5'd19) begin
              epass_ok_r <= 1'b0;
              state_r    <= IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1'b1);
          end
        end
        default: begin
          serial_data_out <= 1'b1;
          state_r         <= IDLE;
        end
      endcase
      if (s3_fall_s) begin
        barrier_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_top_speed.sv
// Directed bench for top_speed: scaled clock (5 cycles per ms, 10 cycles per
// UART bit), expected frame bytes worked out by hand from 360000 / elapsed.
module tb_top_speed;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sensor1 = 1'b0;
  logic sensor2 = 1'b0;
  logic sensor3 = 1'b0;
  logic valid_Epass = 1'b0;
  logic enable = 1'b0;
  logic serial_data_out;

  int n_cmp = 0;
  int n_err = 0;

  top_speed #(
    .SYS_FREQ(5000),
    .BAUD(500),
    .WIDTH_TIK(16),
    .WIDTH_MS(11),
    .WIDTH_SPEED(14)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sensor1(sensor1),
    .sensor2(sensor2),
    .sensor3(sensor3),
    .valid_Epass(valid_Epass),
    .enable(enable),
    .serial_data_out(serial_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts cycles where the line is not idle over a window.
  task automatic watch_idle(input string tag, input int cycles);
    int lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (serial_data_out !== 1'b1) lows++;
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  // Receives one 8N1 byte, sampling mid-bit; start must appear within budget.
  task automatic uart_rx(input string tag, input logic [7:0] exp, input int budget);
    int waited = 0;
    logic [7:0] b;
    b = 8'h00;
    while (serial_data_out === 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " start seen"}, 32'(waited < budget), 32'd1);
    if (waited < budget) begin
      repeat (CPB / 2) @(negedge clk);
      check({tag, " start bit"}, 32'(serial_data_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = serial_data_out;
      end
      repeat (CPB) @(negedge clk);
      check({tag, " stop bit"}, 32'(serial_data_out), 32'd1);
      check({tag, " data"}, 32'(b), 32'(exp));
    end
  endtask

  // One vehicle pass; sensor3 rises n_s3 cycles after sensor1.
  task automatic do_pass(input string tag, input logic epass, input int n_s2, input int n_s3,
                         input bit retrig, input logic [7:0] exp0, input logic [7:0] exp1);
    valid_Epass = epass;
    sensor1 = 1'b1;
    for (int i = 0; i < n_s3; i++) begin
      if (i == n_s2) sensor2 = 1'b1;
      if (retrig && i == 1000) sensor1 = 1'b0;
      if (retrig && i == 1500) sensor1 = 1'b1;
      @(negedge clk);
    end
    sensor3 = 1'b1;
    sensor1 = 1'b0;
    sensor2 = 1'b0;
    uart_rx({tag, " byte0"}, exp0, 60);
    uart_rx({tag, " byte1"}, exp1, 30);
    repeat (20) @(negedge clk);
    sensor3 = 1'b0;
    valid_Epass = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("reset line", 32'(serial_data_out), 32'd1);
    watch_idle("idle after reset", 50);

    // 1200 ms -> elapsed 1199 -> 300; 600 ms -> elapsed 599 -> 601
    do_pass("pass1", 1'b1, 2150, 6000, 1'b0, 8'hC1, 8'h2C);
    do_pass("pass2", 1'b1, 500, 3000, 1'b0, 8'hC2, 8'h59);
    do_pass("pass3", 1'b0, 2150, 6000, 1'b0, 8'h01, 8'h2C);

    // Timeout: 2047 ms at 5 cycles/ms, then sensor3 must be ignored.
    sensor1 = 1'b1;
    watch_idle("timeout no tx", 10500);
    sensor3 = 1'b1;
    watch_idle("s3 after timeout", 300);
    sensor1 = 1'b0;
    sensor3 = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during the byte0 start bit.
    sensor1 = 1'b1;
    repeat (3000) @(negedge clk);
    sensor3 = 1'b1;
    sensor1 = 1'b0;
    waited = 0;
    while (serial_data_out === 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("rst start seen", 32'(waited < 60), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    check("rst line high", 32'(serial_data_out), 32'd1);
    watch_idle("rst no bits", 300);
    sensor3 = 1'b0;
    repeat (20) @(negedge clk);

    // sensor3 pulse in IDLE, then a pass with a sensor1 re-pulse mid-timing.
    sensor3 = 1'b1;
    repeat (30) @(negedge clk);
    sensor3 = 1'b0;
    watch_idle("idle s3 pulse", 300);
    do_pass("retrig", 1'b0, 500, 3000, 1'b1, 8'h02, 8'h59);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top_speed.md
TOP_SPEED -- requirements
Module: top_speed

Interface
REQ-001 SHALL have parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate; CLKS_PER_BIT = SYS_FREQ/BAUD (integer division).
REQ-003 SHALL have parameter WIDTH_TIK, default 16, width of the 1 ms prescaler counter; it must hold SYS_FREQ/1000-1.
REQ-004 SHALL have parameter WIDTH_MS, default 12, width of the elapsed-millisecond counter.
REQ-005 SHALL have parameter WIDTH_SPEED, default 14, width of the speed result in 0.1 km/h units.
REQ-006 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, synchronous reset, active-high: asserted when reset_n=1, despite the name.
REQ-008 SHALL have ports sensor1, sensor2 and sensor3, input, 1 each, asynchronous vehicle-presence levels at the entry, middle and exit positions.
REQ-009 SHALL have port valid_Epass, input, 1, asynchronous; high while a valid e-pass tag is read.
REQ-010 SHALL have port enable, input, 1, asynchronous manual barrier override; high forces the barrier open.
REQ-011 SHALL have port serial_data_out, output, 1, UART TX line, idle high.

Function
REQ-012 SHALL pass every asynchronous input through a 2-flip-flop synchronizer; edges are detected on synchronized values, so detection latency is 3 cycles.
REQ-013 SHALL implement FSM states IDLE, TIMING, CALC and SEND.
REQ-014 SHALL, in IDLE on a sensor1 rising edge, clear the prescaler and ms counter and enter TIMING.
REQ-015 SHALL, in TIMING, increment the ms counter each time the prescaler wraps from SYS_FREQ/1000-1 to 0.
REQ-016 SHALL ignore further sensor1 edges while in TIMING.
REQ-017 SHALL, in TIMING on a sensor2 rising edge, latch epass_ok = synchronized valid_Epass and set barrier = 1 if epass_ok = 1.
REQ-018 SHALL, in TIMING on a sensor3 rising edge, latch elapsed = the ms counter value and enter CALC.
REQ-019 SHALL ignore sensor2 and sensor3 edges while in IDLE.
REQ-020 SHALL return to IDLE from TIMING without transmitting if the ms counter reaches all-ones (timeout).
REQ-021 SHALL, in CALC, compute speed = 360000 / elapsed (0.1 km/h units, fixed 10 m sensor1-to-sensor3 spacing), truncating, with a multi-cycle restoring divider.
REQ-022 SHALL saturate speed to 2^WIDTH_SPEED-1 if elapsed = 0 or the quotient overflows WIDTH_SPEED bits.
REQ-023 SHALL complete the CALC computation within 40 cycles, then enter SEND.
REQ-024 SHALL, in SEND, transmit 2 bytes, 8N1 and LSB first: byte0 = {epass_ok, barrier, speed[13:8]}, then byte1 = speed[7:0].
REQ-025 SHALL return to IDLE after the stop bit of byte1 and clear epass_ok at that point.
REQ-026 SHALL clear barrier on a sensor3 falling edge in any state; the effective barrier value = barrier OR enable.
REQ-027 SHALL keep serial_data_out high whenever not transmitting.
REQ-028 SHALL make byte0 and byte1 contents independent of input changes after the speed value is latched.

Reset
REQ-029 SHALL, on reset, set the FSM to IDLE, clear all counters, epass_ok, barrier and the synchronizers, and drive serial_data_out = 1 on the next cycle.
REQ-030 SHALL, on reset asserted mid-operation (any state, including mid-frame), abort immediately with no resumption.

Verification
REQ-031 SHALL cover: reset, then sensor1 rise, sensor2 rise with valid_Epass=1 at +430 ms, sensor3 rise at +1200 ms -> elapsed 1199..1200, speed 300 (0x012C), UART bytes 0xC1, 0x2C.
REQ-032 SHALL cover: second pass with sensor3 at +600 ms and Epass valid -> speed 600..601, bytes 0xC2, 0x58 (or 0x59).
REQ-033 SHALL cover: the pass of REQ-031 with valid_Epass=0 and enable=0 -> bytes 0x01, 0x2C.
REQ-034 SHALL cover: sensor1 only, no sensor3 -> timeout return to IDLE, serial_data_out stays high.
REQ-035 SHALL cover: reset asserted during the byte0 start bit -> line high next cycle, FSM IDLE, no further bits sent.
REQ-036 SHALL cover: sensor3 pulse while IDLE -> no transmission; a sensor1 pulse during TIMING does not restart the count.
